branch_ctl: RTL and testbench

- Sequences control flow after the branch execution unit resolves a branch: delay-slot tracking, fetch redirect handshake, younger-instruction flush, PR writeback for BSR/JSR/BSRF.
- Sits between the issue stage and fetch.
  - Consumes per-issue branch resolution: taken, target, delay-slot flag, PR-write flag.
  - Drives a redirect request to the fetch unit and a flush to the decode/issue pipeline.
- Also detects slot-illegal conditions (branch issued in a delay slot).

---
 rtl/branch_ctl_pkg.sv | 14 +
 rtl/branch_ctl_if.sv | 40 ++++
 rtl/branch_ctl.sv | 144 ++++++++++++++
 tb/tb_branch_ctl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_ctl_pkg.sv
// Shared definitions for the branch control sequencer: FSM state encoding
// and the PC increment used to form the BSR/JSR/BSRF return address.
package branch_ctl_pkg;

  typedef enum logic [1:0] {
    BRC_IDLE     = 2'd0,
    BRC_DS_WAIT  = 2'd1,
    BRC_REDIRECT = 2'd2
  } brc_state_e;

  // Return address offset: PR receives the branch PC plus this value.
  localparam int unsigned BRC_PC_INC = 4;

endpackage

// File: rtl/branch_ctl_if.sv
// Bundle of issue-side branch resolution, fetch redirect handshake and the
// control outputs of branch_ctl. The master side drives issue/fetch inputs,
// the slave side is the branch controller itself.
interface branch_ctl_if #(
  parameter int ADDR_W = 32
);

  logic              issue_valid;
  logic              issue_is_branch;
  logic [ADDR_W-1:0] issue_pc;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic              br_delayslot;
  logic              br_write_pr;
  logic              ex_flush;
  logic              redirect_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              flush;
  logic              issue_block;
  logic              pr_we;
  logic [ADDR_W-1:0] pr_wdata;
  logic              slot_illegal;
  logic [ADDR_W-1:0] slot_pc;

  modport master (
    output issue_valid, issue_is_branch, issue_pc, br_taken, br_target,
           br_delayslot, br_write_pr, ex_flush, redirect_ready,
    input  redirect_valid, redirect_pc, flush, issue_block, pr_we, pr_wdata,
           slot_illegal, slot_pc
  );

  modport slave (
    input  issue_valid, issue_is_branch, issue_pc, br_taken, br_target,
           br_delayslot, br_write_pr, ex_flush, redirect_ready,
    output redirect_valid, redirect_pc, flush, issue_block, pr_we, pr_wdata,
           slot_illegal, slot_pc
  );

endinterface

// File: rtl/branch_ctl.sv
// Branch control sequencer: tracks delay slots, issues the fetch redirect
// with a valid/ready hold, pulses the younger-instruction flush, writes PR
// for link branches and flags branches placed in a delay slot.
module branch_ctl
  import branch_ctl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter bit SLOT_ILL_EN = 1'b1
) (
  input logic         clk,
  input logic         rst,
  branch_ctl_if.slave bif
);

  brc_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_tgt_q, w_tgt_nxt;
  logic              r_tkn_q, w_tkn_nxt;
  logic              r_flush, w_flush_nxt;
  logic [ADDR_W-1:0] r_redirect_pc, w_redirect_pc_nxt;
  logic              r_pr_we, w_pr_we_nxt;
  logic [ADDR_W-1:0] r_pr_wdata, w_pr_wdata_nxt;
  logic              r_slot_illegal, w_slot_illegal_nxt;
  logic [ADDR_W-1:0] r_slot_pc, w_slot_pc_nxt;

  logic              w_br_issue;
  logic [ADDR_W-1:0] w_ret_addr;

  // An exception flush cancels whatever issues alongside it.
  assign w_br_issue = bif.issue_valid & bif.issue_is_branch & ~bif.ex_flush;
  assign w_ret_addr = bif.issue_pc + ADDR_W'(BRC_PC_INC);

  // Next-state and next-output decode; every target gets its default first.
  always_comb begin
    w_state_nxt        = r_state;
    w_tgt_nxt          = r_tgt_q;
    w_tkn_nxt          = r_tkn_q;
    w_flush_nxt        = 1'b0;
    w_redirect_pc_nxt  = r_redirect_pc;
    w_pr_we_nxt        = 1'b0;
    w_pr_wdata_nxt     = r_pr_wdata;
    w_slot_illegal_nxt = 1'b0;
    w_slot_pc_nxt      = r_slot_pc;

    if (bif.ex_flush) begin
      // Exception flush beats any same-cycle issue or redirect handshake.
      w_state_nxt = BRC_IDLE;
      w_tgt_nxt   = '0;
      w_tkn_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        BRC_IDLE: begin
          if (w_br_issue) begin
            if (bif.br_write_pr) begin
              w_pr_we_nxt    = 1'b1;
              w_pr_wdata_nxt = w_ret_addr;
            end
            if (bif.br_delayslot) begin
              // Not-taken delayed branches still wait so the slot is checked.
              w_tgt_nxt   = bif.br_target;
              w_tkn_nxt   = bif.br_taken;
              w_state_nxt = BRC_DS_WAIT;
            end else if (bif.br_taken) begin
              w_redirect_pc_nxt = bif.br_target;
              w_flush_nxt       = 1'b1;
              w_state_nxt       = BRC_REDIRECT;
            end
          end
        end

        BRC_DS_WAIT: begin
          if (bif.issue_valid) begin
            w_tkn_nxt = 1'b0;
            if (bif.issue_is_branch && SLOT_ILL_EN) begin
              w_slot_illegal_nxt = 1'b1;
              w_slot_pc_nxt      = bif.issue_pc;
              w_state_nxt        = BRC_IDLE;
            end else if (r_tkn_q) begin
              w_redirect_pc_nxt = r_tgt_q;
              w_flush_nxt       = 1'b1;
              w_state_nxt       = BRC_REDIRECT;
            end else begin
              w_state_nxt = BRC_IDLE;
            end
          end
        end

        BRC_REDIRECT: begin
          // PR writeback is independent of the redirect in flight.
          if (w_br_issue && bif.br_write_pr) begin
            w_pr_we_nxt    = 1'b1;
            w_pr_wdata_nxt = w_ret_addr;
          end
          if (bif.redirect_ready) begin
            w_state_nxt = BRC_IDLE;
          end
        end

        default: w_state_nxt = BRC_IDLE;
      endcase
    end
  end

  // FSM state and pending delay-slot branch registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BRC_IDLE;
      r_tgt_q <= '0;
      r_tkn_q <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tgt_q <= w_tgt_nxt;
      r_tkn_q <= w_tkn_nxt;
    end
  end

  // Registered outputs; data values are cleared too so reset state is all-zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush        <= 1'b0;
      r_redirect_pc  <= '0;
      r_pr_we        <= 1'b0;
      r_pr_wdata     <= '0;
      r_slot_illegal <= 1'b0;
      r_slot_pc      <= '0;
    end else begin
      r_flush        <= w_flush_nxt;
      r_redirect_pc  <= w_redirect_pc_nxt;
      r_pr_we        <= w_pr_we_nxt;
      r_pr_wdata     <= w_pr_wdata_nxt;
      r_slot_illegal <= w_slot_illegal_nxt;
      r_slot_pc      <= w_slot_pc_nxt;
    end
  end

  assign bif.redirect_valid = (r_state == BRC_REDIRECT);
  assign bif.redirect_pc    = r_redirect_pc;
  assign bif.flush          = r_flush;
  assign bif.issue_block    = (r_state == BRC_REDIRECT) | r_flush;
  assign bif.pr_we          = r_pr_we;
  assign bif.pr_wdata       = r_pr_wdata;
  assign bif.slot_illegal   = r_slot_illegal;
  assign bif.slot_pc        = r_slot_pc;

endmodule

// File: tb/tb_branch_ctl.sv
// Bench for branch_ctl: two instances (slot-illegal enabled and disabled)
// share one stimulus stream; a behavioural model predicts both.
module tb_branch_ctl;

  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          t_valid, t_isbr, t_taken, t_ds, t_wpr, t_exf, t_ready;
  logic [AW-1:0] t_pc, t_tgt;

  branch_ctl_if #(.ADDR_W(AW)) bif0 ();
  branch_ctl_if #(.ADDR_W(AW)) bif1 ();

  assign bif0.issue_valid = t_valid;   assign bif1.issue_valid = t_valid;
  assign bif0.issue_is_branch = t_isbr; assign bif1.issue_is_branch = t_isbr;
  assign bif0.issue_pc = t_pc;         assign bif1.issue_pc = t_pc;
  assign bif0.br_taken = t_taken;      assign bif1.br_taken = t_taken;
  assign bif0.br_target = t_tgt;       assign bif1.br_target = t_tgt;
  assign bif0.br_delayslot = t_ds;     assign bif1.br_delayslot = t_ds;
  assign bif0.br_write_pr = t_wpr;     assign bif1.br_write_pr = t_wpr;
  assign bif0.ex_flush = t_exf;        assign bif1.ex_flush = t_exf;
  assign bif0.redirect_ready = t_ready; assign bif1.redirect_ready = t_ready;

  branch_ctl #(.ADDR_W(AW), .SLOT_ILL_EN(1'b1)) u_dut0 (.clk(clk), .rst(rst), .bif(bif0.slave));
  branch_ctl #(.ADDR_W(AW), .SLOT_ILL_EN(1'b0)) u_dut1 (.clk(clk), .rst(rst), .bif(bif1.slave));

  logic          o_rv[2], o_flush[2], o_blk[2], o_prwe[2], o_sill[2];
  logic [AW-1:0] o_rpc[2], o_prwd[2], o_spc[2];
  assign o_rv[0] = bif0.redirect_valid;  assign o_rv[1] = bif1.redirect_valid;
  assign o_flush[0] = bif0.flush;        assign o_flush[1] = bif1.flush;
  assign o_blk[0] = bif0.issue_block;    assign o_blk[1] = bif1.issue_block;
  assign o_prwe[0] = bif0.pr_we;         assign o_prwe[1] = bif1.pr_we;
  assign o_sill[0] = bif0.slot_illegal;  assign o_sill[1] = bif1.slot_illegal;
  assign o_rpc[0] = bif0.redirect_pc;    assign o_rpc[1] = bif1.redirect_pc;
  assign o_prwd[0] = bif0.pr_wdata;      assign o_prwd[1] = bif1.pr_wdata;
  assign o_spc[0] = bif0.slot_pc;        assign o_spc[1] = bif1.slot_pc;

  // Reference model: a pending redirect, a pending delay slot, and the
  // one-cycle strobes expected after the next clock edge.
  bit            m_redir[2], m_ds[2], m_dtkn[2];
  logic [AW-1:0] m_rpc[2], m_dtgt[2];
  bit            e_flush[2], e_prwe[2], e_sill[2], e_zero[2];
  logic [AW-1:0] e_prwd[2], e_spc[2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input int i, input bit ill_en);
    e_flush[i] = 1'b0; e_prwe[i] = 1'b0; e_sill[i] = 1'b0; e_zero[i] = 1'b0;
    if (rst) begin
      m_redir[i] = 1'b0; m_ds[i] = 1'b0; m_dtkn[i] = 1'b0; e_zero[i] = 1'b1;
    end else if (t_exf) begin
      m_redir[i] = 1'b0; m_ds[i] = 1'b0; m_dtkn[i] = 1'b0;
    end else if (m_redir[i]) begin
      if (t_valid && t_isbr && t_wpr) begin e_prwe[i] = 1'b1; e_prwd[i] = t_pc + 32'd4; end
      if (t_ready) m_redir[i] = 1'b0;
    end else if (m_ds[i]) begin
      if (t_valid) begin
        m_ds[i] = 1'b0;
        if (t_isbr && ill_en) begin
          e_sill[i] = 1'b1; e_spc[i] = t_pc;
        end else if (m_dtkn[i]) begin
          m_redir[i] = 1'b1; m_rpc[i] = m_dtgt[i]; e_flush[i] = 1'b1;
        end
      end
    end else if (t_valid && t_isbr) begin
      if (t_wpr) begin e_prwe[i] = 1'b1; e_prwd[i] = t_pc + 32'd4; end
      if (t_ds) begin
        m_ds[i] = 1'b1; m_dtkn[i] = t_taken; m_dtgt[i] = t_tgt;
      end else if (t_taken) begin
        m_redir[i] = 1'b1; m_rpc[i] = t_tgt; e_flush[i] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d.redirect_valid", i), AW'(o_rv[i]), AW'(m_redir[i]));
      chk($sformatf("u%0d.flush", i), AW'(o_flush[i]), AW'(e_flush[i]));
      chk($sformatf("u%0d.issue_block", i), AW'(o_blk[i]), AW'(m_redir[i]));
      chk($sformatf("u%0d.pr_we", i), AW'(o_prwe[i]), AW'(e_prwe[i]));
      chk($sformatf("u%0d.slot_illegal", i), AW'(o_sill[i]), AW'(e_sill[i]));
      if (m_redir[i]) chk($sformatf("u%0d.redirect_pc", i), o_rpc[i], m_rpc[i]);
      if (e_prwe[i])  chk($sformatf("u%0d.pr_wdata", i), o_prwd[i], e_prwd[i]);
      if (e_sill[i])  chk($sformatf("u%0d.slot_pc", i), o_spc[i], e_spc[i]);
      if (e_zero[i]) begin
        chk($sformatf("u%0d.rst_redirect_pc", i), o_rpc[i], '0);
        chk($sformatf("u%0d.rst_pr_wdata", i), o_prwd[i], '0);
        chk($sformatf("u%0d.rst_slot_pc", i), o_spc[i], '0);
      end
    end
  endtask

  task automatic idle_in();
    t_valid = 1'b0; t_isbr = 1'b0; t_taken = 1'b0; t_ds = 1'b0; t_wpr = 1'b0;
    t_exf = 1'b0; t_pc = '0; t_tgt = '0;
  endtask

  // One clock: model consumes the same inputs the DUTs sample, then compare.
  task automatic cycle();
    model_step(0, 1'b1);
    model_step(1, 1'b0);
    @(posedge clk);
    #1;
    check_all();
    idle_in();
    rst = 1'b0;
  endtask

  task automatic br(input logic [AW-1:0] pc, input logic [AW-1:0] tgt,
                    input bit taken, input bit ds, input bit wpr);
    t_valid = 1'b1; t_isbr = 1'b1; t_pc = pc; t_tgt = tgt;
    t_taken = taken; t_ds = ds; t_wpr = wpr;
  endtask

  task automatic nonbr(input logic [AW-1:0] pc);
    t_valid = 1'b1; t_isbr = 1'b0; t_pc = pc;
  endtask

  initial begin
    idle_in();
    t_ready = 1'b1;
    rst = 1'b1;
    cycle();
    rst = 1'b1;
    cycle();

    // BT taken, no slot
    br(32'h8C000100, 32'h8C000120, 1'b1, 1'b0, 1'b0);
    cycle();
    chk("bt_redirect_pc", o_rpc[0], 32'h8C000120);
    chk("bt_flush", AW'(o_flush[0]), 32'd1);
    cycle();
    chk("bt_done", AW'(o_rv[0]), 32'd0);

    // BSR with delay slot three cycles later
    br(32'h8C000200, 32'h8C001000, 1'b1, 1'b1, 1'b1);
    cycle();
    chk("bsr_pr_wdata", o_prwd[0], 32'h8C000204);
    cycle();
    cycle();
    nonbr(32'h8C000202);
    cycle();
    chk("bsr_redirect_pc", o_rpc[0], 32'h8C001000);
    cycle();

    // Redirect backpressure
    t_ready = 1'b0;
    br(32'h00000180, 32'h00000200, 1'b1, 1'b0, 1'b0);
    cycle();
    for (int k = 0; k < 4; k++) cycle();
    t_ready = 1'b1;
    cycle();
    cycle();

    // Branch in delay slot
    br(32'h00000100, 32'h00000400, 1'b1, 1'b1, 1'b0);
    cycle();
    br(32'h00000102, 32'h00000500, 1'b1, 1'b0, 1'b1);
    cycle();
    chk("slot_pc_en", o_spc[0], 32'h00000102);
    chk("slot_redirect_dis", o_rpc[1], 32'h00000400);
    cycle();
    cycle();

    // Delayed not-taken
    br(32'h00000300, 32'h00000340, 1'b0, 1'b1, 1'b0);
    cycle();
    nonbr(32'h00000302);
    cycle();
    cycle();

    // ex_flush coincident with the delay slot, then a normal branch
    br(32'h00000600, 32'h00000700, 1'b1, 1'b1, 1'b0);
    cycle();
    nonbr(32'h00000602);
    t_exf = 1'b1;
    cycle();
    cycle();
    cycle();
    br(32'h00000800, 32'h00000900, 1'b1, 1'b0, 1'b0);
    cycle();
    cycle();

    // PR return address wraps modulo 2^ADDR_W
    br(32'hFFFFFFFC, 32'h00000010, 1'b0, 1'b0, 1'b1);
    cycle();
    chk("pr_wrap", o_prwd[0], 32'h00000000);

    // Reset in the middle of a stalled redirect
    t_ready = 1'b0;
    br(32'h00000A00, 32'h00000B00, 1'b1, 1'b0, 1'b1);
    cycle();
    rst = 1'b1;
    cycle();
    t_ready = 1'b1;
    cycle();

    // Randomized traffic; issue respects issue_block of both instances
    for (int n = 0; n < 600; n++) begin
      rst     = ($urandom_range(0, 149) == 0);
      t_exf   = ($urandom_range(0, 19) == 0);
      t_ready = ($urandom_range(0, 2) != 0);
      if (!m_redir[0] && !m_redir[1] && $urandom_range(0, 1) == 1) begin
        t_valid = 1'b1;
        t_isbr  = ($urandom_range(0, 2) == 0);
        t_pc    = {$urandom_range(0, 65535), 16'h0} | AW'($urandom_range(0, 4095) * 2);
        t_tgt   = $urandom;
        t_taken = $urandom_range(0, 1) == 1;
        t_ds    = $urandom_range(0, 1) == 1;
        t_wpr   = $urandom_range(0, 2) == 0;
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
